// File: rtl/audio_sample_pkg.sv
// Shared widths, source-select encoding and the mono mixing helper for the
// audio sample conditioner.
package audio_sample_pkg;

    localparam int unsigned SAMPLE_WIDTH       = 24;
    localparam int unsigned DROP_COUNT_WIDTH   = 16;
    localparam int unsigned SAMPLE_COUNT_WIDTH = 32;

    typedef enum logic [1:0] {
        SRC_MONO  = 2'd0,
        SRC_LEFT  = 2'd1,
        SRC_RIGHT = 2'd2,
        SRC_ZERO  = 2'd3
    } src_sel_e;

    // (L+R) at one extra bit, then arithmetic shift right: floor average.
    function automatic logic [SAMPLE_WIDTH-1:0] mono_avg(input logic [SAMPLE_WIDTH-1:0] left,
                                                         input logic [SAMPLE_WIDTH-1:0] right);
        logic signed [SAMPLE_WIDTH:0] sum;
        sum = $signed({left[SAMPLE_WIDTH-1], left}) + $signed({right[SAMPLE_WIDTH-1], right});
        return SAMPLE_WIDTH'(sum >>> 1);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO; DEPTH must be a power of two, at least 2.
// Read data reads as zero while empty.
module sample_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q;
    logic [PTR_WIDTH-1:0] rd_ptr_q;
    logic [PTR_WIDTH:0]   count_q;
    logic                 do_wr;
    logic                 do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_WIDTH + 1)'(DEPTH));
    assign count   = count_q;
    assign do_rd   = rd_en & ~empty;
    // A write into a full FIFO is legal when the head leaves in the same cycle.
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/audio_sample_conditioner.sv
// Synchronizes the audio-driver strobe, selects/mixes a source, boxcar-decimates
// and queues samples for the downstream pipeline, with drop accounting.
module audio_sample_conditioner
    import audio_sample_pkg::*;
#(
    parameter int unsigned DECIM      = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          advance,
    input  logic [SAMPLE_WIDTH-1:0]       adc_left,
    input  logic [SAMPLE_WIDTH-1:0]       adc_right,
    input  logic                          enable,
    input  logic [1:0]                    src_sel,
    input  logic                          clr_overflow,
    output logic [SAMPLE_WIDTH-1:0]       sample_out,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic                          overflow,
    output logic [DROP_COUNT_WIDTH-1:0]   drop_count,
    output logic [SAMPLE_COUNT_WIDTH-1:0] sample_count
);

    localparam int unsigned LOG_DECIM   = $clog2(DECIM);
    localparam int unsigned ACC_WIDTH   = SAMPLE_WIDTH + LOG_DECIM;
    localparam int unsigned PHASE_WIDTH = (LOG_DECIM > 0) ? LOG_DECIM : 1;
    localparam int unsigned COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic                          sync1_q, sync2_q, sync3_q;
    logic                          capture;
    logic [SAMPLE_WIDTH-1:0]       selected;
    logic                          sel_valid_q;
    logic signed [SAMPLE_WIDTH-1:0] sel_data_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [ACC_WIDTH-1:0]   acc_sum;
    logic [PHASE_WIDTH-1:0]        phase_q;
    logic                          phase_last;
    logic                          push_q;
    logic [SAMPLE_WIDTH-1:0]       push_data_q;

    logic                          fifo_full;
    logic                          fifo_empty;
    logic [COUNT_WIDTH-1:0]        fifo_count;
    logic                          pop;
    logic                          accept;
    logic                          drop;

    assign capture = sync2_q & ~sync3_q;

    always_comb begin
        selected = '0;
        unique case (src_sel_e'(src_sel))
            SRC_MONO:  selected = mono_avg(adc_left, adc_right);
            SRC_LEFT:  selected = adc_left;
            SRC_RIGHT: selected = adc_right;
            SRC_ZERO:  selected = '0;
        endcase
    end

    assign acc_sum    = acc_q + ACC_WIDTH'(sel_data_q);
    assign phase_last = (phase_q == PHASE_WIDTH'(DECIM - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            // All stages reset high so a strobe already high at release is not an edge.
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync3_q     <= 1'b1;
            sel_valid_q <= 1'b0;
            sel_data_q  <= '0;
            acc_q       <= '0;
            phase_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            sync1_q     <= advance;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            sel_valid_q <= capture & enable;
            sel_data_q  <= selected;
            push_q      <= 1'b0;
            if (!enable) begin
                acc_q   <= '0;
                phase_q <= '0;
            end else if (sel_valid_q) begin
                if (phase_last) begin
                    acc_q       <= '0;
                    phase_q     <= '0;
                    push_q      <= 1'b1;
                    push_data_q <= SAMPLE_WIDTH'(acc_sum >>> LOG_DECIM);
                end else begin
                    acc_q   <= acc_sum;
                    phase_q <= phase_q + 1'b1;
                end
            end
        end
    end

    assign sample_valid = ~fifo_empty;
    assign pop          = sample_valid & sample_ready;
    assign accept       = push_q & (~fifo_full | pop);
    assign drop         = push_q & fifo_full & ~pop;

    sample_fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data (push_data_q),
        .rd_en   (pop),
        .rd_data (sample_out),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow     <= 1'b0;
            drop_count   <= '0;
            sample_count <= '0;
        end else begin
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
            if (accept) begin
                sample_count <= sample_count + 1'b1;
            end
        end
    end

    occupancy_bounded: assert property (@(posedge clk) disable iff (reset)
        fifo_count <= COUNT_WIDTH'(FIFO_DEPTH));

endmodule

// File: tb/tb_audio_sample_conditioner.sv
// Directed bench for audio_sample_conditioner: one DECIM=1 and one DECIM=4 instance.
module tb_audio_sample_conditioner;

    logic        clk;
    logic        reset;
    logic        advance;
    logic        advance4;
    logic [23:0] adc_left;
    logic [23:0] adc_right;
    logic        enable;
    logic [1:0]  src_sel;
    logic        clr_overflow;
    logic        sample_ready;

    logic [23:0] sample_out,   sample_out4;
    logic        sample_valid, sample_valid4;
    logic        overflow,     overflow4;
    logic [15:0] drop_count,   drop_count4;
    logic [31:0] sample_count, sample_count4;

    int tests_run;
    int tests_failed;

    audio_sample_conditioner #(
        .DECIM      (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .advance      (advance),
        .adc_left     (adc_left),
        .adc_right    (adc_right),
        .enable       (enable),
        .src_sel      (src_sel),
        .clr_overflow (clr_overflow),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .sample_count (sample_count)
    );

    audio_sample_conditioner #(
        .DECIM      (4),
        .FIFO_DEPTH (4)
    ) dut4 (
        .clk          (clk),
        .reset        (reset),
        .advance      (advance4),
        .adc_left     (adc_left),
        .adc_right    (adc_right),
        .enable       (enable),
        .src_sel      (src_sel),
        .clr_overflow (clr_overflow),
        .sample_out   (sample_out4),
        .sample_valid (sample_valid4),
        .sample_ready (sample_ready),
        .overflow     (overflow4),
        .drop_count   (drop_count4),
        .sample_count (sample_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        advance  = 1'b0;
        advance4 = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    // One strobe on the selected instance; the push lands on the 5th tick.
    task automatic pulse(input logic [23:0] l, input logic [23:0] r, input bit use4);
        adc_left  = l;
        adc_right = r;
        if (use4) advance4 = 1'b1;
        else      advance  = 1'b1;
        repeat (3) tick();
        advance  = 1'b0;
        advance4 = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (sample_valid !== 1'b0) begin tests_failed++;
            $display("FAIL reset valid: got %b want 0", sample_valid); end
        tests_run++; if (sample_out !== 24'h0) begin tests_failed++;
            $display("FAIL reset sample_out: got %h want 000000", sample_out); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++;
            $display("FAIL reset overflow: got %b want 0", overflow); end
        tests_run++; if (drop_count !== 16'h0) begin tests_failed++;
            $display("FAIL reset drop_count: got %h want 0000", drop_count); end
        tests_run++; if (sample_count !== 32'h0) begin tests_failed++;
            $display("FAIL reset sample_count: got %h want 0", sample_count); end
        tests_run++; if (sample_valid4 !== 1'b0) begin tests_failed++;
            $display("FAIL reset valid4: got %b want 0", sample_valid4); end
    endtask

    task automatic test_mono_latency();
        do_reset();
        adc_left     = 24'h000004;
        adc_right    = 24'h000002;
        src_sel      = 2'd0;
        sample_ready = 1'b1;
        advance      = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests_run++; if (sample_valid !== (i == 4)) begin tests_failed++;
                $display("FAIL latency valid cycle %0d: got %b want %b", i, sample_valid, i == 4); end
        end
        tests_run++; if (sample_out !== 24'h000003) begin tests_failed++;
            $display("FAIL mono basic data: got %h want 000003", sample_out); end
        advance = 1'b0;
        repeat (3) tick();
        tests_run++; if (sample_count !== 32'd1) begin tests_failed++;
            $display("FAIL mono basic count: got %0d want 1", sample_count); end
        tests_run++; if (sample_valid !== 1'b0) begin tests_failed++;
            $display("FAIL mono basic drained: got %b want 0", sample_valid); end
    endtask

    task automatic test_mono_corners();
        logic [23:0] exp [3];
        exp[0] = 24'h7FFFFF;
        exp[1] = 24'h800000;
        exp[2] = 24'hFFFFFF;
        do_reset();
        sample_ready = 1'b0;
        src_sel      = 2'd0;
        pulse(24'h7FFFFF, 24'h7FFFFF, 1'b0);
        pulse(24'h800000, 24'h800000, 1'b0);
        pulse(24'hFFFFFF, 24'h000000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (sample_valid !== 1'b1 || sample_out !== exp[i]) begin tests_failed++;
                $display("FAIL mono corner %0d: got %b/%h want 1/%h", i, sample_valid, sample_out,
                         exp[i]); end
            sample_ready = 1'b1;
            tick();
            sample_ready = 1'b0;
        end
        tests_run++; if (sample_valid !== 1'b0) begin tests_failed++;
            $display("FAIL mono corner drained: got %b want 0", sample_valid); end
    endtask

    task automatic test_decim4();
        logic [23:0] vals [3];
        vals[0] = 24'd10;
        vals[1] = 24'd20;
        vals[2] = 24'd30;
        do_reset();
        sample_ready = 1'b0;
        src_sel      = 2'd1;
        for (int i = 0; i < 3; i++) begin
            pulse(vals[i], 24'd0, 1'b1);
            tests_run++; if (sample_valid4 !== 1'b0) begin tests_failed++;
                $display("FAIL decim4 early output after %0d: got %b want 0", i + 1, sample_valid4); end
        end
        pulse(24'd41, 24'd0, 1'b1);
        tests_run++; if (sample_valid4 !== 1'b1 || sample_out4 !== 24'd25) begin tests_failed++;
            $display("FAIL decim4 average: got %b/%0d want 1/25", sample_valid4, sample_out4); end
        tests_run++; if (sample_count4 !== 32'd1) begin tests_failed++;
            $display("FAIL decim4 count: got %0d want 1", sample_count4); end
        tests_run++; if (sample_count !== 32'd0) begin tests_failed++;
            $display("FAIL decim4 other instance: got %0d want 0", sample_count); end
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        // Mixed sources in one window: 8 + 12 + 2 + 0 = 22, floor(22/4) = 5.
        src_sel = 2'd1; pulse(24'd8, 24'd99, 1'b1);
        src_sel = 2'd2; pulse(24'd99, 24'd12, 1'b1);
        src_sel = 2'd0; pulse(24'd4, 24'd0, 1'b1);
        src_sel = 2'd3; pulse(24'd77, 24'd77, 1'b1);
        tests_run++; if (sample_valid4 !== 1'b1 || sample_out4 !== 24'd5) begin tests_failed++;
            $display("FAIL decim4 mixed sources: got %b/%0d want 1/5", sample_valid4, sample_out4); end
    endtask

    task automatic test_enable();
        do_reset();
        sample_ready = 1'b0;
        src_sel      = 2'd1;
        enable       = 1'b0;
        pulse(24'd50, 24'd0, 1'b0);
        tests_run++; if (sample_count !== 32'd0 || sample_valid !== 1'b0) begin tests_failed++;
            $display("FAIL enable gate: got %0d/%b want 0/0", sample_count, sample_valid); end
        enable = 1'b1;
        pulse(24'd100, 24'd0, 1'b1);
        enable = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) pulse(24'd4, 24'd0, 1'b1);
        tests_run++; if (sample_valid4 !== 1'b0) begin tests_failed++;
            $display("FAIL enable phase clear: got %b want 0", sample_valid4); end
        pulse(24'd4, 24'd0, 1'b1);
        tests_run++; if (sample_valid4 !== 1'b1 || sample_out4 !== 24'd4) begin tests_failed++;
            $display("FAIL enable acc clear: got %b/%0d want 1/4", sample_valid4, sample_out4); end
    endtask

    task automatic test_overflow();
        do_reset();
        sample_ready = 1'b0;
        src_sel      = 2'd1;
        for (int i = 1; i <= 6; i++) pulse(24'(i), 24'd0, 1'b0);
        tests_run++; if (overflow !== 1'b1) begin tests_failed++;
            $display("FAIL overflow set: got %b want 1", overflow); end
        tests_run++; if (drop_count !== 16'd2) begin tests_failed++;
            $display("FAIL overflow drop_count: got %0d want 2", drop_count); end
        tests_run++; if (sample_count !== 32'd4) begin tests_failed++;
            $display("FAIL overflow sample_count: got %0d want 4", sample_count); end
        adc_left = 24'd7;
        advance  = 1'b1;
        repeat (4) tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        advance      = 1'b0;
        tests_run++; if (overflow !== 1'b1 || drop_count !== 16'd3) begin tests_failed++;
            $display("FAIL clear vs drop: got %b/%0d want 1/3", overflow, drop_count); end
        repeat (3) tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        tests_run++; if (overflow !== 1'b0 || drop_count !== 16'd3) begin tests_failed++;
            $display("FAIL clear alone: got %b/%0d want 0/3", overflow, drop_count); end
        for (int i = 1; i <= 4; i++) begin
            tests_run++; if (sample_valid !== 1'b1 || sample_out !== 24'(i)) begin tests_failed++;
                $display("FAIL overflow order %0d: got %b/%0d want 1/%0d", i, sample_valid,
                         sample_out, i); end
            sample_ready = 1'b1;
            tick();
            sample_ready = 1'b0;
        end
        tests_run++; if (sample_valid !== 1'b0) begin tests_failed++;
            $display("FAIL overflow drained: got %b want 0", sample_valid); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        sample_ready = 1'b0;
        src_sel      = 2'd1;
        for (int i = 11; i <= 14; i++) pulse(24'(i), 24'd0, 1'b0);
        adc_left = 24'd15;
        advance  = 1'b1;
        repeat (4) tick();
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        advance      = 1'b0;
        tests_run++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin tests_failed++;
            $display("FAIL full push+pop drop: got %0d/%b want 0/0", drop_count, overflow); end
        tests_run++; if (sample_count !== 32'd5) begin tests_failed++;
            $display("FAIL full push+pop count: got %0d want 5", sample_count); end
        repeat (3) tick();
        for (int i = 12; i <= 15; i++) begin
            tests_run++; if (sample_valid !== 1'b1 || sample_out !== 24'(i)) begin tests_failed++;
                $display("FAIL full push+pop order %0d: got %b/%0d want 1/%0d", i, sample_valid,
                         sample_out, i); end
            sample_ready = 1'b1;
            tick();
            sample_ready = 1'b0;
        end
        tests_run++; if (sample_valid !== 1'b0) begin tests_failed++;
            $display("FAIL full push+pop occupancy: got %b want 0", sample_valid); end
    endtask

    task automatic test_advance_sync();
        sample_ready = 1'b0;
        src_sel      = 2'd1;
        adc_left     = 24'h123456;
        reset        = 1'b1;
        advance      = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        tests_run++; if (sample_count !== 32'd0 || sample_valid !== 1'b0) begin tests_failed++;
            $display("FAIL held across reset: got %0d/%b want 0/0", sample_count, sample_valid); end
        advance = 1'b0;
        repeat (5) tick();
        advance = 1'b1;
        repeat (100) tick();
        advance = 1'b0;
        repeat (5) tick();
        tests_run++; if (sample_count !== 32'd1) begin tests_failed++;
            $display("FAIL long strobe captures: got %0d want 1", sample_count); end
        tests_run++; if (sample_out !== 24'h123456) begin tests_failed++;
            $display("FAIL long strobe data: got %h want 123456", sample_out); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        advance      = 1'b0;
        advance4     = 1'b0;
        adc_left     = '0;
        adc_right    = '0;
        enable       = 1'b1;
        src_sel      = 2'd0;
        clr_overflow = 1'b0;
        sample_ready = 1'b0;

        test_reset();
        test_mono_latency();
        test_mono_corners();
        test_decim4();
        test_enable();
        test_overflow();
        test_full_push_pop();
        test_advance_sync();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
